extbus_seq: RTL

- Request sequencer feeding the external 72-bit bus (64 data + 8 tag) from the processor side.
- Accepts processor read/write requests into a 4-deep posted queue, matching the four-word external bus buffer.
- Issues each request to main memory over a four-phase req/ack handshake, with a bus-timeout watchdog.
- Returns read data to the processor in strict request order.

---
 rtl/extbus_pkg.sv | 15 +
 rtl/extbus_fifo.sv | 47 ++++
 rtl/extbus_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/extbus_pkg.sv
// Shared widths, request record and sequencer states for the external 72-bit bus.
package extbus_pkg;
  localparam int WORD_W = 72;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 8;
  localparam int ADDR_W = 20;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;
endpackage

// File: rtl/extbus_fifo.sv
// Circular posted-request queue; head is the oldest entry, valid while not empty.
module extbus_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  // Pointers are log2(DEPTH) wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
endmodule

// File: rtl/extbus_seq.sv
// Processor-side request sequencer: posted queue, four-phase memory handshake,
// bus-timeout watchdog and in-order read return.
module extbus_seq
  import extbus_pkg::*;
#(
  parameter int AW      = ADDR_W,
  parameter int DW      = WORD_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t                 state;
  logic [TW-1:0]          timer;
  req_t                   q_din, q_head;
  logic [$clog2(DEPTH):0] q_count;
  logic                   q_full, q_empty, q_push, q_pop;
  logic                   expired;

  assign q_din     = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign cpu_ready = !q_full;
  assign q_push    = cpu_req && cpu_ready;
  assign expired   = (timer == TLAST);
  // The head stays queued while in flight and leaves on ack or timeout.
  assign q_pop     = (state == S_WAIT) && (mem_ack || expired);
  assign busy      = (q_count != '0) || (state != S_IDLE);

  extbus_fifo #(.W($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      bus_err    <= 1'b0;
    end else begin
      cpu_rvalid <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        S_IDLE:
          if (!q_empty) begin
            mem_req   <= 1'b1;
            mem_we    <= q_head.we;
            mem_addr  <= q_head.addr;
            mem_wdata <= q_head.wdata;
            timer     <= '0;
            state     <= S_WAIT;
          end
        S_WAIT:
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              cpu_rvalid <= 1'b1;
              cpu_rdata  <= mem_rdata;
            end
            state <= S_RELEASE;
          end else if (expired) begin
            // A timed-out read still answers, with zero data, to keep order.
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            if (!mem_we) begin
              cpu_rvalid <= 1'b1;
              cpu_rdata  <= '0;
            end
            state <= S_RELEASE;
          end else begin
            timer <= timer + 1'b1;
          end
        S_RELEASE:
          if (!mem_ack) state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
endmodule
